fixed_point_mac: RTL and testbench
==================================

# fixed_point_mac

Parametrised, pipelined signed fixed-point multiply-accumulate for the convolution datapath. It multiplies a streamed weight by a streamed pixel and sums TAPS consecutive valid products into one kernel-window result. It then saturates or wraps the sum to the output format and emits it with a one-cycle valid pulse. It generalises the fixed 19×10→26 multiplier: widths, kernel size, pipeline depth and overflow mode are all configurable, and it adds valid qualification, accumulation, a synchronous clear and an overflow flag.

## Interface
- W_WIDTH, 19, weight width, signed; default format sfix19_En18
- W_FRAC, 18, weight fractional bits; output keeps the same fractional bits
- P_WIDTH, 10, pixel width, signed integer (sfix10_En0)
- OUT_WIDTH, 26, output width (sfix26_En18 by default)
- TAPS, 9, products per window, ≥1
- MULT_STAGES, 2, product pipeline registers, ≥1
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
- clk  in  1  single clock, rising edge
- GlobalReset  in  1  asynchronous, active-low reset
- InValid  in  1  WeightPort/PixelPort carry a tap this cycle
- SyncClear  in  1  synchronous abort of the current window
- WeightPort  in  W_WIDTH  signed weight
- PixelPort  in  P_WIDTH  signed pixel
- OutValid  out  1  one-cycle pulse, Output holds a new result
- Output  out  OUT_WIDTH  window sum, holds between results
- Overflow  out  1  qualified by OutValid; result exceeded OUT_WIDTH range

## Operation
- Product is a full-precision signed product of width W_WIDTH+P_WIDTH, carried through MULT_STAGES registers together with its valid bit.
- Accumulator width is ACC_W = W_WIDTH+P_WIDTH+clog2(TAPS). The accumulator itself never overflows.
- Tap counter 0..TAPS-1 advances only on valid products arriving at the accumulate stage.
  - First tap: acc ← product.
  - Other taps: acc ← acc + product.
  - Tap TAPS-1: the final sum goes to the output stage, and the counter wraps to 0 in the same cycle.
- Bubbles (InValid=0) are allowed anywhere. They do not advance the counter and do not disturb the accumulator.
- Output stage: no shift; the sum's binary point equals W_FRAC.
  - If the sum lies in [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], Output is the sum and Overflow is 0.
  - Otherwise Overflow is 1. With SATURATE=1, Output clamps to the nearest bound; with SATURATE=0, Output is the low OUT_WIDTH bits.
- SyncClear:
  - Zeroes all pipeline valid bits, the tap counter and the accumulator on the next edge.
  - Drops any window in flight. Output is unchanged and OutValid is 0 on the following cycle.
  - SyncClear and InValid in the same cycle: clear wins and the sample is dropped.
- TAPS=1: every valid sample produces its own result.
- No backpressure. The upstream may present a tap every cycle, and results may then arrive back-to-back every TAPS cycles.

## Timing
- Reset (GlobalReset=0, asynchronous): OutValid=0, Output=0, Overflow=0, tap counter=0, accumulator=0, all pipeline valid bits 0. Takes effect immediately, including mid-window. The partial window is lost.
- Latency: OutValid rises exactly LAT = MULT_STAGES+2 rising edges after the edge that samples the last tap of a window. With defaults this is 4.
- Throughput: one tap per cycle; one result per TAPS valid taps.
- OutValid is high for exactly one cycle per result. Overflow is meaningful only while OutValid=1 and reads 0 otherwise.
- Output changes only on a cycle with OutValid=1 or on reset.

## Structure
- Package fixed_point_pkg holds:
  - default width and fraction constants (19/18/10/26);
  - a clog2 function;
  - a function that saturates or wraps a signed value to N bits and returns the value plus an overflow flag.
- Sub-module signed_mult_pipe holds the MULT_STAGES-deep signed product register chain with the valid chain and synchronous flush.
- fixed_point_mac holds the tap counter, accumulator, clear logic and output stage.

## Test plan
- Defaults; 9 taps of weight 65536 (0.25) × pixel 10 → single OutValid 4 edges after the 9th tap, Output=5898240 (22.5), Overflow=0.
- Defaults; 9 taps of 131072 × 100 → Output=33554431, Overflow=1. The same with weight -131072 → Output=-33554432, Overflow=1.
- SATURATE=0; 9 taps of 131072 × 100 → Output=-16252928, Overflow=1.
- Defaults; 9 taps with random bubbles between them, then 18 back-to-back taps of 65536 × 10 → three results of 5898240, with the last two spaced exactly 9 cycles apart.
- SyncClear after tap 5, then 9 taps of 65536 × 4 → no output for the aborted window, then one result of 2359296 (9.0). GlobalReset asserted after tap 3 → all outputs 0 immediately, and the next 9 taps yield a correct result.
- TAPS=1, MULT_STAGES=1; weight -262144 (-1.0) × pixel -512 → OutValid 3 edges later, Overflow=1, Output=33554431.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared constants and helpers for the fixed-point MAC datapath
// Provides default operand/output formats, a constant clog2 and a saturate-or-wrap folder.
package fixed_point_pkg;
    localparam int DEF_W_WIDTH   = 19;
    localparam int DEF_W_FRAC    = 18;
    localparam int DEF_P_WIDTH   = 10;
    localparam int DEF_OUT_WIDTH = 26;

    typedef struct packed {
        logic               ovf;
        logic signed [63:0] value;
    } sat_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Range-checks v against an n-bit signed format; the caller keeps the low n bits of value,
    // which is the clamped bound when sat is set, or v itself (two's-complement wrap) otherwise.
    function automatic sat_t sat_wrap(input logic signed [63:0] v, input int n, input logic sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t r;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.ovf = (v > hi) || (v < lo);
        r.value = (r.ovf && sat) ? ((v < 0) ? lo : hi) : v;
        return r;
    endfunction
endpackage

// File: rtl/fixed_point_mac_mult.sv
// signed_mult_pipe: operand register plus STAGES-deep signed product chain with valid bits
// Ports: clk, rst_n (async low), flush_i (sync drop of all valids), valid_i/a_i/b_i in, valid_o/prod_o out.
module signed_mult_pipe #(
    parameter int A_W    = 19,
    parameter int B_W    = 10,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [A_W-1:0]       a_i,
    input  logic [B_W-1:0]       b_i,
    output logic                 valid_o,
    output logic [A_W+B_W-1:0]   prod_o
);
    localparam int P_W = A_W + B_W;

    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;
    logic                  in_vld_q;
    logic [P_W-1:0]        prod_q [STAGES];
    logic [STAGES-1:0]     vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            in_vld_q <= 1'b0;
            vld_q    <= '0;
            for (int i = 0; i < STAGES; i++) prod_q[i] <= '0;
        end else begin
            a_q       <= $signed(a_i);
            b_q       <= $signed(b_i);
            in_vld_q  <= valid_i & ~flush_i;
            prod_q[0] <= P_W'(a_q) * P_W'(b_q);
            vld_q[0]  <= in_vld_q & ~flush_i;
            for (int i = 1; i < STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1] & ~flush_i;
            end
        end
    end

    assign valid_o = vld_q[STAGES-1];
    assign prod_o  = prod_q[STAGES-1];
endmodule

// File: rtl/fixed_point_mac.sv
// fixed_point_mac: pipelined signed MAC summing TAPS products per window, then saturating or wrapping
// Ports: clk, GlobalReset (async low), InValid/SyncClear/WeightPort/PixelPort in; OutValid/Output/Overflow out.
module fixed_point_mac
    import fixed_point_pkg::*;
#(
    parameter int W_WIDTH     = DEF_W_WIDTH,
    parameter int W_FRAC      = DEF_W_FRAC,
    parameter int P_WIDTH     = DEF_P_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int TAPS        = 9,
    parameter int MULT_STAGES = 2,
    parameter int SATURATE    = 1
) (
    input  logic                 clk,
    input  logic                 GlobalReset,
    input  logic                 InValid,
    input  logic                 SyncClear,
    input  logic [W_WIDTH-1:0]   WeightPort,
    input  logic [P_WIDTH-1:0]   PixelPort,
    output logic                 OutValid,
    output logic [OUT_WIDTH-1:0] Output,
    output logic                 Overflow
);
    localparam int P_W   = W_WIDTH + P_WIDTH;
    localparam int CW    = TAPS > 1 ? clog2(TAPS) : 1;
    localparam int ACC_W = P_W + clog2(TAPS);

    // Output keeps the weight's binary point, so a fraction wider than the weight is meaningless.
    if (W_FRAC > W_WIDTH) begin : g_bad_frac
        $error("W_FRAC exceeds W_WIDTH");
    end

    logic                    p_vld;
    logic [P_W-1:0]          prod;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, fin_q;
    logic                    fin_vld_q, last;
    logic                    out_vld_q, ovf_q;
    logic [OUT_WIDTH-1:0]    out_q;
    sat_t                    fold;

    signed_mult_pipe #(
        .A_W   (W_WIDTH),
        .B_W   (P_WIDTH),
        .STAGES(MULT_STAGES)
    ) u_mult (
        .clk    (clk),
        .rst_n  (GlobalReset),
        .flush_i(SyncClear),
        .valid_i(InValid),
        .a_i    (WeightPort),
        .b_i    (PixelPort),
        .valid_o(p_vld),
        .prod_o (prod)
    );

    // The first tap of a window restarts the sum instead of adding to the stale accumulator.
    always_comb begin
        last  = cnt_q == CW'(TAPS - 1);
        acc_d = (cnt_q == '0 ? '0 : acc_q) + ACC_W'($signed(prod));
        cnt_d = last ? '0 : cnt_q + CW'(1);
        fold  = sat_wrap(64'(fin_q), OUT_WIDTH, SATURATE != 0);
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            fin_q     <= '0;
            fin_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            out_q     <= '0;
        end else if (SyncClear) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            fin_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (p_vld) begin
                cnt_q <= cnt_d;
                acc_q <= acc_d;
            end
            if (p_vld && last) fin_q <= acc_d;
            fin_vld_q <= p_vld && last;
            out_vld_q <= fin_vld_q;
            ovf_q     <= fin_vld_q && fold.ovf;
            if (fin_vld_q) out_q <= OUT_WIDTH'(fold.value);
        end
    end

    assign OutValid = out_vld_q;
    assign Output   = out_q;
    assign Overflow = ovf_q;
endmodule

// File: tb/tb_fixed_point_mac.sv
// tb_fixed_point_mac: directed plus random checks of three MAC configurations against a window model
module tb_fixed_point_mac;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, in_v, clr;
    logic signed [18:0] w;
    logic signed [9:0]  p;
    logic               ov [3];
    logic               of [3];
    logic signed [25:0] out [3];

    fixed_point_mac u0 (
        .clk(clk), .GlobalReset(rst_n), .InValid(in_v), .SyncClear(clr), .WeightPort(w),
        .PixelPort(p), .OutValid(ov[0]), .Output(out[0]), .Overflow(of[0]));
    fixed_point_mac #(.SATURATE(0)) u1 (
        .clk(clk), .GlobalReset(rst_n), .InValid(in_v), .SyncClear(clr), .WeightPort(w),
        .PixelPort(p), .OutValid(ov[1]), .Output(out[1]), .Overflow(of[1]));
    fixed_point_mac #(.TAPS(1), .MULT_STAGES(1)) u2 (
        .clk(clk), .GlobalReset(rst_n), .InValid(in_v), .SyncClear(clr), .WeightPort(w),
        .PixelPort(p), .OutValid(ov[2]), .Output(out[2]), .Overflow(of[2]));

    int     taps [3] = '{9, 9, 1};
    int     lat  [3] = '{4, 4, 3};
    bit     satm [3] = '{1'b1, 1'b0, 1'b1};
    int     cnt  [3];
    longint acc  [3];
    longint held [3];
    bit     ev_v   [3][8];
    longint ev_val [3][8];
    bit     ev_of  [3][8];
    longint last_out [3];
    bit     last_of  [3];
    int     cyc, total, bad, nres, rc_prev, rc_last, rc2, n0, s2;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic void fold(input longint s, input bit sat, output longint v, output bit o);
        longint lim;
        lim = longint'(1) << 25;
        o = (s > lim - 1) || (s < -lim);
        v = s;
        if (o && sat) v = (s < 0) ? -lim : lim - 1;
        else if (o) begin
            v = (s + lim) % (2 * lim);
            if (v < 0) v += 2 * lim;
            v -= lim;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0;
            acc[k] = 0;
            held[k] = 0;
            for (int j = 0; j < 8; j++) ev_v[k][j] = 1'b0;
        end
    endfunction

    task automatic check_all();
        int  slot;
        bit  e;
        for (int k = 0; k < 3; k++) begin
            slot = cyc % 8;
            e = ev_v[k][slot];
            chk($sformatf("ovalid%0d", k), ov[k], e);
            chk($sformatf("out%0d", k), out[k], e ? ev_val[k][slot] : held[k]);
            chk($sformatf("ovf%0d", k), of[k], e ? ev_of[k][slot] : 1'b0);
            if (e) held[k] = ev_val[k][slot];
            ev_v[k][slot] = 1'b0;
            if (ov[k] === 1'b1) begin
                last_out[k] = out[k];
                last_of[k] = of[k];
                if (k == 0) begin
                    nres++;
                    rc_prev = rc_last;
                    rc_last = cyc;
                end
                if (k == 2) rc2 = cyc;
            end
        end
    endtask

    task automatic clock(input bit v, input bit c, input int wv, input int pv);
        longint prod, fv;
        bit     fo;
        int     slot;
        in_v = v;
        clr  = c;
        w    = 19'(wv);
        p    = 10'(pv);
        @(posedge clk);
        cyc++;
        prod = longint'(w) * longint'(p);
        for (int k = 0; k < 3; k++) begin
            if (c) begin
                cnt[k] = 0;
                acc[k] = 0;
                for (int j = 0; j < 8; j++) ev_v[k][j] = 1'b0;
            end else if (v) begin
                acc[k] = (cnt[k] == 0) ? prod : acc[k] + prod;
                cnt[k]++;
                if (cnt[k] == taps[k]) begin
                    fold(acc[k], satm[k], fv, fo);
                    slot = (cyc + lat[k]) % 8;
                    ev_v[k][slot] = 1'b1;
                    ev_val[k][slot] = fv;
                    ev_of[k][slot] = fo;
                    cnt[k] = 0;
                end
            end
        end
        #1 check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clock(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_v = 1'b0; clr = 1'b0; w = '0; p = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ovalid", ov[k], 1'b0);
            chk("rst_out", out[k], 0);
            chk("rst_ovf", of[k], 1'b0);
        end
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 9; i++) clock(1'b1, 1'b0, 65536, 10);
        idle(6);
        chk("t1_out", last_out[0], 5898240);
        chk("t1_ovf", last_of[0], 1'b0);

        for (int i = 0; i < 9; i++) clock(1'b1, 1'b0, 131072, 100);
        idle(6);
        chk("sat_hi_out", last_out[0], 33554431);
        chk("sat_hi_ovf", last_of[0], 1'b1);
        chk("wrap_out", last_out[1], -16252928);
        chk("wrap_ovf", last_of[1], 1'b1);

        for (int i = 0; i < 9; i++) clock(1'b1, 1'b0, -131072, 100);
        idle(6);
        chk("sat_lo_out", last_out[0], -33554432);
        chk("sat_lo_ovf", last_of[0], 1'b1);

        n0 = nres;
        for (int i = 0; i < 9; i++) begin
            idle($urandom_range(0, 3));
            clock(1'b1, 1'b0, 65536, 10);
        end
        for (int i = 0; i < 18; i++) clock(1'b1, 1'b0, 65536, 10);
        idle(6);
        chk("b2b_count", nres - n0, 3);
        chk("b2b_out", last_out[0], 5898240);
        chk("b2b_spacing", rc_last - rc_prev, 9);

        n0 = nres;
        for (int i = 0; i < 5; i++) clock(1'b1, 1'b0, 65536, 10);
        clock(1'b1, 1'b1, 65536, 10);
        for (int i = 0; i < 9; i++) clock(1'b1, 1'b0, 65536, 4);
        idle(6);
        chk("clr_count", nres - n0, 1);
        chk("clr_out", last_out[0], 2359296);

        for (int i = 0; i < 3; i++) clock(1'b1, 1'b0, 65536, 10);
        rst_n = 1'b0;
        #2;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk("arst_ovalid", ov[k], 1'b0);
            chk("arst_out", out[k], 0);
            chk("arst_ovf", of[k], 1'b0);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 9; i++) clock(1'b1, 1'b0, 65536, 10);
        idle(6);
        chk("arst_next_out", last_out[0], 5898240);

        clock(1'b1, 1'b0, -262144, -512);
        s2 = cyc;
        idle(5);
        chk("taps1_out", last_out[2], 33554431);
        chk("taps1_ovf", last_of[2], 1'b1);
        chk("taps1_lat", rc2 - s2, 3);

        for (int i = 0; i < 400; i++)
            clock($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, int'($urandom), int'($urandom));
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
